pll_reset_seq: RTL and testbench



---
 rtl/pll_reset_seq_pkg.sv | 25 ++
 rtl/pll_reset_seq_if.sv | 24 ++
 rtl/pll_reset_seq_sync.sv | 25 ++
 rtl/pll_reset_seq.sv | 112 +++++++++++
 tb/tb_pll_reset_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
// Holds the state encoding driven on the `state` output and the
// width function for the shared cycle counter.
package pll_seq_pkg;

  // Encoding is externally visible on the `state` port and must not change.
  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Width of the shared counter: enough bits to reach the longest interval.
  function automatic int cnt_width(input int rst_cycles,
                                   input int lock_timeout,
                                   input int stable_cycles);
    int max_v;
    max_v = rst_cycles;
    if (lock_timeout > max_v) max_v = lock_timeout;
    if (stable_cycles > max_v) max_v = stable_cycles;
    return (max_v > 1) ? $clog2(max_v) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// PLL-side and core-side signals of the reset sequencer.
// master: the sequencer; slave: the PLL / reset-tree / monitor side.
interface pll_reset_seq_if #(
  parameter int CNT_W = 8
);

  logic             pll_locked;
  logic             pll_rst;
  logic             core_rst;
  logic             ready;
  logic [CNT_W-1:0] relock_cnt;
  logic [1:0]       state;

  modport master (
    input  pll_locked,
    output pll_rst, core_rst, ready, relock_cnt, state
  );

  modport slave (
    output pll_locked,
    input  pll_rst, core_rst, ready, relock_cnt, state
  );

endinterface

// File: rtl/pll_reset_seq_sync.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous
// active-high reset; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the asynchronous input time to settle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both flops sample their inputs
    // from before the edge; blocking here would collapse the chain.
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse and lock qualification before the core
// reset is released; re-sequences on lock loss and counts those events.
// Build option: define PLL_SEQ_TIMEOUT_EN to enable the WAIT_LOCK timeout;
// without it WAIT_LOCK waits indefinitely and only RUN lock losses count.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic            refclk,
  input  logic            rst,
  pll_reset_seq_if.master bus
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
`endif
  // The WAIT_LOCK cycle that first sees locked_s already counts as one
  // qualified cycle, so STABLE itself only needs STABLE_CYCLES-1 more.
  localparam logic [CW-1:0] STABLE_LAST =
    CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] RELOCK_MAX = '1;

  logic             locked_s;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic             relock_inc;
  logic             pll_rst_q, core_rst_q, ready_q;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and relock counter update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    relock_inc = 1'b0;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_RESET_PLL;
          relock_inc = 1'b1;
        end
`endif
      end
      ST_STABLE: begin
        // A dropout here is treated as a glitch: retry without counting.
        if (!locked_s)                 state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d    = ST_RESET_PLL;
          relock_inc = 1'b1;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase

    // Counter restarts from zero on every state entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    relock_d = relock_q;
    if (relock_inc && (relock_q != RELOCK_MAX)) relock_d = relock_q + 1'b1;
  end

  // State register; outputs are decoded from the next state so they
  // switch on the same edge as the state itself.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ST_RESET_PLL;
      cnt_q      <= '0;
      relock_q   <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      relock_q   <= relock_d;
      pll_rst_q  <= (state_d == ST_RESET_PLL);
      core_rst_q <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.ready      = ready_q;
  assign bus.relock_cnt = relock_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Cycle c is the period ending at the c-th rising edge
// after rst is released; inputs are driven and outputs sampled on the
// falling edge inside that period.
module tb_pll_reset_seq;

  logic refclk;
  logic rst;

  pll_reset_seq_if #(.CNT_W(8)) bus_a ();
  pll_reset_seq_if #(.CNT_W(2)) bus_b ();

  pll_reset_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .CNT_W(8)
  ) u_dut_a (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus_a)
  );

  pll_reset_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .CNT_W(2)
  ) u_dut_b (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pll_rst/core_rst/ready follow from the expected state.
  task automatic check_a(input string ph, input int c,
                         input logic [1:0] es, input int er);
    string p;
    p = $sformatf("%s c%0d", ph, c);
    check({p, " state"},      bus_a.state,      es);
    check({p, " pll_rst"},    bus_a.pll_rst,    es == 2'd0);
    check({p, " core_rst"},   bus_a.core_rst,   es != 2'd3);
    check({p, " ready"},      bus_a.ready,      es == 2'd3);
    check({p, " relock_cnt"}, bus_a.relock_cnt, er);
  endtask

  task automatic next_cyc();
    @(negedge refclk);
  endtask

  // Hold rst for two edges, release it; caller is then in cycle 0.
  task automatic restart();
    @(negedge refclk);
    rst = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] exp_a(input int c);
    if (c <= 3)  return 2'd0;
    if (c <= 8)  return 2'd1;
    if (c <= 15) return 2'd2;
    return 2'd3;
  endfunction

  // Glitch in STABLE, lock loss in RUN twice, then rst during a lock loss.
  function automatic logic [1:0] exp_b_state(input int c);
    if (c <= 3)  return 2'd0;
    if (c <= 8)  return 2'd1;
    if (c <= 13) return 2'd2;
    if (c == 14) return 2'd1;
    if (c <= 21) return 2'd2;
    if (c <= 27) return 2'd3;
    if (c <= 31) return 2'd0;
    if (c == 32) return 2'd1;
    if (c <= 39) return 2'd2;
    if (c <= 44) return 2'd3;
    if (c <= 48) return 2'd0;
    if (c == 49) return 2'd1;
    if (c <= 56) return 2'd2;
    if (c <= 59) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int exp_b_relock(input int c);
    if (c < 28)  return 0;
    if (c < 45)  return 1;
    if (c < 60)  return 2;
    return 0;
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  initial begin
    logic [1:0] es;
    int         er;
    rst = 1'b1;
    bus_a.pll_locked = 1'b0;
    bus_b.pll_locked = 1'b0;

    // Phase A: clean start, lock at cycle 6, release at cycle 16.
    restart();
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) next_cyc();
      if (c == 6) bus_a.pll_locked = 1'b1;
      check_a("A", c, exp_a(c), 0);
      if (c == 7) check("A locked_s c7", u_dut_a.locked_s, 1'b0);
      if (c == 8) check("A locked_s c8", u_dut_a.locked_s, 1'b1);
    end

    // Phase B: glitch in STABLE, two RUN lock losses, rst over a loss.
    bus_a.pll_locked = 1'b0;
    restart();
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) next_cyc();
      case (c)
        6, 12, 26, 43: bus_a.pll_locked = 1'b1;
        11, 25, 42, 57: bus_a.pll_locked = 1'b0;
        59:            rst = 1'b1;
        default: ;
      endcase
      check_a("B", c, exp_b_state(c), exp_b_relock(c));
    end

    // Phase C: lock never arrives.
    bus_a.pll_locked = 1'b0;
    restart();
    for (int c = 0; c <= 73; c++) begin
      if (c > 0) next_cyc();
`ifdef PLL_SEQ_TIMEOUT_EN
      es = ((c % 24) < 4) ? 2'd0 : 2'd1;
      er = c / 24;
`else
      es = (c < 4) ? 2'd0 : 2'd1;
      er = 0;
`endif
      check_a("C", c, es, er);
    end

    // Phase D: 2-bit relock counter, five RUN lock losses.
    restart();
    for (int c = 0; c <= 116; c++) begin
      if (c > 0) next_cyc();
      if (c == 6) bus_b.pll_locked = 1'b1;
      if (c >= 20 && c <= 100 && (c % 20) == 0) bus_b.pll_locked = 1'b0;
      if (c >= 21 && c <= 101 && (c % 20) == 1) bus_b.pll_locked = 1'b1;
      if (c >= 22 && c <= 102 && (c % 20) == 2) begin
        check($sformatf("D c%0d state", c), bus_b.state, 2'd3);
        check($sformatf("D c%0d relock_cnt", c), bus_b.relock_cnt,
              sat3(c / 20 - 1));
      end
      if (c >= 23 && c <= 103 && (c % 20) == 3) begin
        check($sformatf("D c%0d state", c), bus_b.state, 2'd0);
        check($sformatf("D c%0d pll_rst", c), bus_b.pll_rst, 1'b1);
        check($sformatf("D c%0d relock_cnt", c), bus_b.relock_cnt,
              sat3(c / 20));
      end
      if (c == 116) begin
        check("D c116 state", bus_b.state, 2'd3);
        check("D c116 relock_cnt", bus_b.relock_cnt, 2'd3);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
